// File: rtl/snes_serial_tx.sv
`default_nettype none
// ============================================================================
// snes_serial_tx : SNES controller emulation, console-clocked 16-bit transmitter
// Revision: 1.0
// ============================================================================
module snes_serial_tx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] button_word,
  input  logic        snes_latch,
  input  logic        snes_clk,
  output logic        serial_out,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic                   latch_dly_q;
  logic                   sclk_dly_q;

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        sout_q, sout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic latch_lvl;
  logic latch_fall;
  logic sclk_rise;

  // The console clock idles high, so its chain resets to 1 to avoid a false rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync_q <= '0;
      sclk_sync_q  <= '1;
      latch_dly_q  <= 1'b0;
      sclk_dly_q   <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], snes_latch};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], snes_clk};
      latch_dly_q  <= latch_sync_q[SYNC_STAGES-1];
      sclk_dly_q   <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign latch_lvl  = latch_sync_q[SYNC_STAGES-1];
  assign latch_fall = ~latch_lvl & latch_dly_q;
  assign sclk_rise  = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    sout_d  = sout_q;
    done_d  = 1'b0;

    if (latch_lvl) begin
      state_d = LOAD;
      shreg_d = button_word;
      cnt_d   = '0;
      sout_d  = ~button_word[0];
    end else begin
      case (state_q)
        IDLE: begin
          sout_d = 1'b1;
          cnt_d  = '0;
        end
        LOAD: begin
          if (latch_fall) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shreg_d = {1'b0, shreg_q[15:1]};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = DONE;
              sout_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              sout_d = ~shreg_q[1];
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            sout_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        DONE: begin
          sout_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          sout_d  = 1'b1;
        end
      endcase
    end

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign serial_out = sout_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_serial_tx.sv
`default_nettype none
// ============================================================================
// tb_snes_serial_tx : frame-level checks of snes_serial_tx against a bit-index model
// Revision: 1.0
// ============================================================================
module tb_snes_serial_tx;

  localparam int SYNC = 2;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        snes_latch;
  logic        snes_clk;
  logic        toggle_en;
  logic [15:0] bw_drv;
  logic [15:0] tog_word = 16'hFFFF;
  logic [15:0] button_word;
  logic        serial_out;
  logic        busy;
  logic        frame_done;

  int n_total  = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int tog_phase = 0;

  typedef struct {
    logic [15:0] word;
    int          pulses;
    logic        exp_busy;
    logic        exp_sout;
    int          exp_inc;
  } vec_t;

  vec_t vecs[6];

  snes_serial_tx #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_word(button_word),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  assign button_word = toggle_en ? tog_word : bw_drv;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  always @(posedge clk) begin
    if (tog_phase == 2) begin
      tog_phase <= 0;
      tog_word  <= ~tog_word;
    end else begin
      tog_phase <= tog_phase + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Console sees bit k after k clock rises; after 16 rises the line is held low.
  function automatic logic exp_bit(input logic [15:0] w, input int k);
    if (k >= 16) return 1'b0;
    return ~w[k];
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_pulse(input int lo, input int hi);
    snes_clk = 1'b0;
    wait_cyc(lo);
    snes_clk = 1'b1;
    wait_cyc(hi);
  endtask

  task automatic latch_frame(input logic [15:0] w);
    bw_drv     = w;
    snes_latch = 1'b1;
    wait_cyc(25);
    snes_latch = 1'b0;
    wait_cyc(6);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int pulses, input int lo, input int hi);
    for (int k = 0; k < pulses; k++) begin
      if (k < 16) begin
        check("stream_bit", 32'(serial_out), 32'(exp_bit(w, k)));
        check("busy_in_shift", 32'(busy), 32'd1);
      end
      clk_pulse(lo, hi);
    end
  endtask

  task automatic run_frame(input logic [15:0] w, input int pulses, input int lo, input int hi,
                           output int inc);
    int start;
    start = done_cnt;
    latch_frame(w);
    shift_bits(w, pulses, lo, hi);
    inc = done_cnt - start;
  endtask

  initial begin
    int inc;
    int start;
    logic [15:0] w;
    int p, lo, hi;

    vecs[0] = '{16'h0001, 16, 1'b0, 1'b0, 1};
    vecs[1] = '{16'hA5C3, 16, 1'b0, 1'b0, 1};
    vecs[2] = '{16'h0000, 20, 1'b0, 1'b0, 1};
    vecs[3] = '{16'h1234,  7, 1'b1, 1'b1, 0};
    vecs[4] = '{16'h8000, 15, 1'b1, 1'b0, 0};
    vecs[5] = '{16'hFFFF,  0, 1'b1, 1'b0, 0};

    reset_n    = 1'b1;
    snes_latch = 1'b0;
    snes_clk   = 1'b1;
    toggle_en  = 1'b0;
    bw_drv     = 16'h0000;
    #2 reset_n = 1'b0;
    #1;
    check("reset_sout", 32'(serial_out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(3);
    check("idle_sout", 32'(serial_out), 32'd1);

    // Latch-to-output latency: change lands on edge SYNC+1.
    bw_drv     = 16'h0003;
    snes_latch = 1'b1;
    wait_cyc(1);
    check("lat_edge1_busy", 32'(busy), 32'd0);
    wait_cyc(1);
    check("lat_edge2_busy", 32'(busy), 32'd0);
    check("lat_edge2_sout", 32'(serial_out), 32'd1);
    wait_cyc(1);
    check("lat_edge3_busy", 32'(busy), 32'd1);
    check("lat_edge3_sout", 32'(serial_out), 32'd0);
    wait_cyc(20);
    snes_latch = 1'b0;
    wait_cyc(6);
    check("after_fall_busy", 32'(busy), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].word, vecs[i].pulses, 6, 6, inc);
      check("vec_end_sout", 32'(serial_out), 32'(vecs[i].exp_sout));
      check("vec_end_busy", 32'(busy), 32'(vecs[i].exp_busy));
      check("vec_done_inc", 32'(inc), 32'(vecs[i].exp_inc));
      check("vec_done_low", 32'(frame_done), 32'd0);
    end

    // Clock rises while latch is high must not shift.
    start = done_cnt;
    bw_drv     = 16'h5A5A;
    snes_latch = 1'b1;
    wait_cyc(8);
    clk_pulse(5, 8);
    clk_pulse(5, 8);
    snes_latch = 1'b0;
    wait_cyc(6);
    shift_bits(16'h5A5A, 16, 5, 5);
    check("clk_in_latch_done", 32'(done_cnt - start), 32'd1);

    // Aborted frame followed by a full one.
    run_frame(16'h1234, 7, 6, 6, inc);
    check("abort_no_done", 32'(inc), 32'd0);
    run_frame(16'hC0DE, 16, 6, 6, inc);
    check("second_frame_done", 32'(inc), 32'd1);
    check("second_frame_sout", 32'(serial_out), 32'd0);

    // Timeout with no console clock.
    start = done_cnt;
    latch_frame(16'hFFFF);
    check("tmo_busy_start", 32'(busy), 32'd1);
    wait_cyc(TMO / 2);
    check("tmo_busy_mid", 32'(busy), 32'd1);
    wait_cyc(TMO);
    check("tmo_busy_end", 32'(busy), 32'd0);
    check("tmo_sout_end", 32'(serial_out), 32'd1);
    check("tmo_no_done", 32'(done_cnt - start), 32'd0);

    // Rise spacing below the timeout but total frame far longer than it.
    run_frame(16'h3C3C, 16, 20, 30, inc);
    check("slow_frame_done", 32'(inc), 32'd1);

    // Button word churning during SHIFT and DONE.
    start = done_cnt;
    latch_frame(16'h6E91);
    toggle_en = 1'b1;
    shift_bits(16'h6E91, 16, 5, 5);
    wait_cyc(10);
    check("churn_done_sout", 32'(serial_out), 32'd0);
    check("churn_done_inc", 32'(done_cnt - start), 32'd1);
    toggle_en = 1'b0;

    // Asynchronous reset at bit 9.
    start = done_cnt;
    latch_frame(16'hFFFF);
    shift_bits(16'hFFFF, 9, 5, 5);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_sout", 32'(serial_out), 32'd0);
    reset_n = 1'b0;
    #2;
    check("async_rst_sout", 32'(serial_out), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(4);
    check("rst_no_done", 32'(done_cnt - start), 32'd0);
    run_frame(16'h0F0F, 16, 6, 6, inc);
    check("post_rst_done", 32'(inc), 32'd1);

    for (int r = 0; r < 20; r++) begin
      w  = 16'($urandom);
      p  = int'($urandom_range(0, 20));
      lo = int'($urandom_range(4, 12));
      hi = int'($urandom_range(4, 12));
      run_frame(w, p, lo, hi, inc);
      check("rnd_end_sout", 32'(serial_out), 32'(exp_bit(w, p)));
      check("rnd_end_busy", 32'(busy), (p < 16) ? 32'd1 : 32'd0);
      check("rnd_done_inc", 32'(inc), (p >= 16) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snes_serial_tx.md
SNES_SERIAL_TX -- requirements
Module: snes_serial_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each console input (legal 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, number of clk cycles without a console clock rising edge in SHIFT before abort (legal 16..65535).
REQ-003 SHALL have port clk  input  1  system clock (internal oscillator, nominal 2.08 MHz).
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port button_word  input  16  controller state from selection mux, bit n = 1 means button n pressed, bit 0 shifted first.
REQ-006 SHALL have port snes_latch  input  1  console LATCH, asynchronous to clk, active-high.
REQ-007 SHALL have port snes_clk  input  1  console CLOCK, asynchronous to clk, idle high.
REQ-008 SHALL have port serial_out  output  1  console DATA line, active-low (0 = pressed), registered.
REQ-009 SHALL have port busy  output  1  high in LOAD and SHIFT states, registered.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when the 16th bit is shifted out, registered.

Function
REQ-011 SHALL synchronize snes_latch and snes_clk each through SYNC_STAGES flops; all logic SHALL use only synchronized versions.
REQ-012 SHALL detect latch rise, latch fall and clock rise by comparing last sync stage with a one-cycle-delayed copy.
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, DONE; reset state IDLE.
REQ-014 Synchronized latch high in any state SHALL force LOAD on next clk edge (latch has priority over every other event).
REQ-015 In LOAD: 16-bit shift register SHALL load button_word every cycle; serial_out SHALL equal ~button_word[0] as loaded.
REQ-016 Latch fall in LOAD SHALL transition to SHIFT with bit counter = 0, freezing the last loaded word.
REQ-017 In SHIFT each clock rise SHALL shift register right by one (zero fill), increment counter, serial_out = ~new bit 0.
REQ-018 Clock rise with counter = 15 SHALL transition to DONE, drive serial_out = 0, assert frame_done for exactly one cycle.
REQ-019 In DONE serial_out SHALL remain 0; clock rises SHALL be ignored; only latch leaves DONE.
REQ-020 In IDLE clock rises SHALL be ignored and serial_out SHALL be 1.
REQ-021 Timeout counter SHALL clear on entry to SHIFT and on each clock rise; reaching TIMEOUT_CYCLES-1 in SHIFT SHALL go to IDLE without frame_done.
REQ-022 Clock rise coincident with latch high SHALL not shift; register reloads per REQ-015.
REQ-023 Changes of button_word during SHIFT or DONE SHALL not affect serial_out.
REQ-024 Latency: serial_out/state change SHALL occur on the (SYNC_STAGES+1)th clk edge, counting the edge that first samples the console transition as edge 1.
REQ-025 busy SHALL be 1 exactly when next-registered state is LOAD or SHIFT.

Reset
REQ-026 reset_n low SHALL immediately (asynchronously) force state IDLE, shift register 0, counters 0, synchronizers 0 except snes_clk chain to 1, serial_out = 1, busy = 0, frame_done = 0.
REQ-027 After reset_n release no edge SHALL be reported on the first cycle; reset mid-frame SHALL discard the frame.

Verification
REQ-028 button_word=16'h0001, latch 12 us pulse, 16 clock pulses -> serial_out 0 then fifteen 1s, then 0 held; frame_done one pulse after 16th rise.
REQ-029 button_word=16'hA5C3 -> sampled serial stream LSB-first equals ~16'hA5C3; busy high from latch until DONE.
REQ-030 Latch, 7 clock pulses, new latch, 16 pulses -> first frame aborted, no frame_done for it, second frame complete and correct.
REQ-031 Latch then no clock for TIMEOUT_CYCLES cycles -> state IDLE, serial_out 1, busy 0, frame_done never asserted.
REQ-032 button_word toggled 16'hFFFF/16'h0000 every 3 cycles during SHIFT -> stream equals word captured at latch fall.
REQ-033 reset_n pulsed low at bit 9 -> serial_out 1, busy 0 asynchronously; next latch frame correct.
